// File: rtl/led_trail_pwm.sv
// led_trail_pwm
// Turns a one-hot "flowing LED" pattern into a fading trail. Each channel
// keeps an 8-bit brightness that jumps to full scale while its input bit is
// high. It then decays by DECAY_STEP every DECAY_DIV clocks and is rendered
// with a shared 8-bit PWM counter.
//
// Parameters:
//   DECAY_DIV  - clock cycles per decay tick (1..2^32-1)
//   DECAY_STEP - brightness units removed per decay tick (1..255)
// Ports:
//   clk     in   system clock, all state changes on rising edge
//   rst_n   in   asynchronous active-low reset
//   led_in  in   [7:0] raw flow pattern, synchronous to clk
//   led_out out  [7:0] registered PWM drive per channel
//   active  out  registered, high while any channel brightness is nonzero
module led_trail_pwm #(
    parameter logic [31:0] DECAY_DIV  = 32'd195_313,
    parameter logic [7:0]  DECAY_STEP = 8'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] led_in,
    output logic [7:0] led_out,
    output logic       active
);

    logic [7:0]  pwm_cnt_q;
    logic [7:0]  pwm_cnt_d;
    logic [31:0] div_cnt_q;
    logic [31:0] div_cnt_d;
    logic        decay_tick;
    logic [7:0]  bright_q [8];
    logic [7:0]  bright_d [8];
    logic [7:0]  led_out_q;
    logic [7:0]  led_out_d;
    logic        active_q;
    logic        active_d;

    // Shared timebase: free-running PWM counter and decay-tick divider.
    always_comb begin
        pwm_cnt_d  = pwm_cnt_q + 8'd1;
        decay_tick = (div_cnt_q == (DECAY_DIV - 32'd1));
        if (decay_tick) begin
            div_cnt_d = 32'd0;
        end else begin
            div_cnt_d = div_cnt_q + 32'd1;
        end
    end

    // Per-channel brightness update and PWM/activity decode.
    always_comb begin
        led_out_d = 8'h00;
        active_d  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            // A fresh input reload wins over a decay tick in the same cycle.
            if (led_in[i]) begin
                bright_d[i] = 8'd255;
            end else if (decay_tick) begin
                // Saturate at zero instead of wrapping.
                if (bright_q[i] > DECAY_STEP) begin
                    bright_d[i] = bright_q[i] - DECAY_STEP;
                end else begin
                    bright_d[i] = 8'd0;
                end
            end else begin
                bright_d[i] = bright_q[i];
            end
            // Full scale is forced on so 255 never shows a one-cycle gap at pwm_cnt==255.
            led_out_d[i] = (bright_q[i] == 8'd255) || (bright_q[i] > pwm_cnt_q);
            if (bright_q[i] != 8'd0) begin
                active_d = 1'b1;
            end else begin
                active_d = active_d;
            end
        end
    end

    // State and output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= 8'd0;
            div_cnt_q <= 32'd0;
            led_out_q <= 8'h00;
            active_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                bright_q[i] <= 8'd0;
            end
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            div_cnt_q <= div_cnt_d;
            led_out_q <= led_out_d;
            active_q  <= active_d;
            for (int i = 0; i < 8; i++) begin
                bright_q[i] <= bright_d[i];
            end
        end
    end

    assign led_out = led_out_q;
    assign active  = active_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Self-checking bench for led_trail_pwm. Two instances share clk, rst_n and
// led_in:
//   dut_a - DECAY_DIV=4, DECAY_STEP=64
//   dut_b - DECAY_DIV=4, DECAY_STEP=100 (saturation case)
// Every clock, the outputs of both instances are compared against a
// behavioural model. That model works from the edge count since reset
// release and keeps brightness as plain integers.
module tb_led_trail_pwm;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] led_in = 8'h00;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic       act_a;
    logic       act_b;

    always #5 clk = ~clk;

    led_trail_pwm #(.DECAY_DIV(32'd4), .DECAY_STEP(8'd64)) dut_a (
        .clk(clk), .rst_n(rst_n), .led_in(led_in), .led_out(out_a), .active(act_a));
    led_trail_pwm #(.DECAY_DIV(32'd4), .DECAY_STEP(8'd100)) dut_b (
        .clk(clk), .rst_n(rst_n), .led_in(led_in), .led_out(out_b), .active(act_b));

    int n_checks = 0;
    int n_fail = 0;

    // Model state: rising edges since release, brightness per instance/channel.
    int         k;
    int         mb [2][8];
    int         steps [2] = '{64, 100};
    logic [7:0] eo [2];
    logic       ea [2];

    typedef struct {
        logic [7:0] in;
        logic [7:0] out;
        logic       act;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, k);
        end
    endtask

    task automatic model_clear();
        k = 0;
        for (int d = 0; d < 2; d++) begin
            eo[d] = 8'h00;
            ea[d] = 1'b0;
            for (int i = 0; i < 8; i++) mb[d][i] = 0;
        end
    endtask

    // One rising edge: outputs come from pre-edge brightness, then brightness moves.
    task automatic model_edge();
        int  pwm;
        bit  tick;
        pwm  = k % 256;
        tick = ((k + 1) % DIV) == 0;
        for (int d = 0; d < 2; d++) begin
            eo[d] = 8'h00;
            ea[d] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (mb[d][i] == 255 || mb[d][i] > pwm) eo[d][i] = 1'b1;
                if (mb[d][i] != 0) ea[d] = 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
                if (led_in[i]) mb[d][i] = 255;
                else if (tick) mb[d][i] = (mb[d][i] > steps[d]) ? mb[d][i] - steps[d] : 0;
            end
        end
        k++;
    endtask

    task automatic cyc(input logic [7:0] v);
        led_in = v;
        @(posedge clk);
        model_edge();
        #1;
        chk("led_out_a", out_a, eo[0]);
        chk("active_a", act_a, ea[0]);
        chk("led_out_b", out_b, eo[1]);
        chk("active_b", act_b, ea[1]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        led_in = 8'h00;
        model_clear();
        #1;
        chk("rst_led_out", {out_b, out_a}, 16'h0000);
        chk("rst_active", {act_b, act_a}, 2'b00);
        @(negedge clk);
        chk("rst_pwm_cnt", dut_a.pwm_cnt_q, 8'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{8'h01, 8'h00, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 1'b1};
        tbl[2] = '{8'h80, 8'h01, 1'b1};
        tbl[3] = '{8'h00, 8'h81, 1'b1};
        tbl[4] = '{8'h00, 8'h81, 1'b1};
        tbl[5] = '{8'h02, 8'h81, 1'b1};
        tbl[6] = '{8'h00, 8'h83, 1'b1};
        tbl[7] = '{8'h00, 8'h83, 1'b1};

        model_clear();
        #2;
        do_reset();

        // Table vectors from a fresh release, one edge each.
        for (int j = 0; j < 8; j++) begin
            cyc(tbl[j].in);
            chk($sformatf("tbl%0d_out", j), out_a, tbl[j].out);
            chk($sformatf("tbl%0d_act", j), act_a, tbl[j].act);
        end

        // Held input: continuously on from the second edge.
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            cyc(8'h01);
            if (n >= 2) chk("hold_out", out_a, 8'h01);
        end

        // Single-cycle load then fade, both step sizes, with saturation.
        do_reset();
        cyc(8'h01);
        for (int n = 2; n <= 24; n++) begin
            int t;
            int ea_v;
            int eb_v;
            cyc(8'h00);
            t    = n / DIV;
            ea_v = 255 - 64 * t;
            eb_v = 255 - 100 * t;
            chk("fade_bright_a", dut_a.bright_q[0], (ea_v < 0) ? 0 : ea_v);
            chk("fade_bright_b", dut_b.bright_q[0], (eb_v < 0) ? 0 : eb_v);
            if (n == 16) chk("fade_active_last", act_a, 1'b1);
            if (n == 17) chk("fade_active_fall", act_a, 1'b0);
            if (n >= 13) chk("sat_out_b", out_b, 8'h00);
        end

        // Reload colliding with a decay tick while bright[3]=127.
        do_reset();
        cyc(8'h08);
        for (int n = 2; n <= 11; n++) cyc(8'h00);
        chk("pre_collide", dut_a.bright_q[3], 8'd127);
        cyc(8'h08);
        chk("collide_reload", dut_a.bright_q[3], 8'd255);
        for (int n = 0; n < 8; n++) cyc(8'h00);

        // Asynchronous reset mid-fade.
        do_reset();
        cyc(8'h01);
        for (int n = 2; n <= 9; n++) cyc(8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", out_a, 8'h00);
        chk("async_rst_act", act_a, 1'b0);
        chk("async_rst_bright", dut_a.bright_q[0], 8'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            cyc(8'h00);
            chk("post_rst_quiet", {act_a, out_a}, 9'h000);
        end

        // Flow pattern, 64 cycles per position, spanning PWM wraps.
        do_reset();
        for (int n = 0; n < 64; n++) cyc(8'h80);
        for (int n = 0; n < 64; n++) cyc(8'h01);
        for (int n = 0; n < 64; n++) cyc(8'h02);
        chk("flow_cur", out_a[1], 1'b1);
        for (int n = 0; n < 300; n++) cyc(8'h00);

        // Randomised stimulus against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] v;
            case ($urandom_range(0, 9))
                0:       v = 8'($urandom_range(0, 255));
                1, 2:    v = 8'h01 << $urandom_range(0, 7);
                default: v = 8'h00;
            endcase
            cyc(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_trail_pwm.md
LED_TRAIL_PWM -- requirements
Module: led_trail_pwm

Interface
REQ-001 Parameter DECAY_DIV, default 32'd195_313, clock cycles per decay tick; legal range 1..2^32-1; a sim bench uses 4.
REQ-002 Parameter DECAY_STEP, default 8'd4, brightness units removed per decay tick; legal range 1..255.
REQ-003 Port clk  input  1  single system clock (50 MHz inner clock); all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port led_in  input  8  raw one-hot flow pattern from the upstream flow-LED stage, synchronous to clk.
REQ-006 Port led_out  output  8  registered PWM drive to the board LEDs, giving a fading trail behind each lit position.
REQ-007 Port active  output  1  registered; high while any channel brightness is nonzero.

Function
REQ-008 pwm_cnt shall be an 8-bit free-running counter, +1 per cycle, wrapping 255->0.
REQ-009 div_cnt shall count 0..DECAY_DIV-1 and wrap to 0; decay_tick shall be high for exactly the cycle in which div_cnt==DECAY_DIV-1.
REQ-010 With DECAY_DIV==1, decay_tick shall be high every cycle.
REQ-011 Each channel i shall hold an 8-bit brightness bright[i].
REQ-012 If led_in[i]==1 at a rising edge, bright[i] shall load 255; load has priority over a simultaneous decay_tick.
REQ-013 Else, if decay_tick, bright[i] shall become bright[i]-DECAY_STEP when bright[i]>DECAY_STEP, otherwise 0 (saturating, no wrap).
REQ-014 Else bright[i] shall hold.
REQ-015 led_out[i] shall register (bright[i]==255) OR (bright[i]>pwm_cnt): 255 = always on, 0 = always off, N = on N of every 256 cycles.
REQ-016 Latency: led_in[i] rising sampled at edge n -> bright[i]=255 after edge n -> led_out[i]=1 after edge n+1.
REQ-017 active shall register OR-reduction of all bright[i]!=0, with the same one-cycle latency as led_out.
REQ-018 Multiple led_in bits high at once (non-one-hot) shall be handled per channel independently; no error flagging.
REQ-019 Channels shall never interact; decay_tick and pwm_cnt are shared by all channels.

Reset
REQ-020 While rst_n==0, pwm_cnt, div_cnt and every bright[i] shall be 0, led_out shall be 8'h00 and active 0, applied asynchronously on the falling edge of rst_n.
REQ-021 Release of rst_n shall take effect at the next rising edge of clk; the first decay_tick shall occur DECAY_DIV cycles after release.
REQ-022 Reset asserted mid-fade shall discard all brightness; no trail resumes after release unless led_in re-asserts.

Verification (DECAY_DIV=4, DECAY_STEP=64 unless noted)
REQ-023 led_in=8'h01 held from reset release -> led_out=8'h01 from the second edge onward, continuously high; active=1.
REQ-024 led_in=8'h01 for 1 cycle then 8'h00 -> bright[0] steps 255,191,127,63,0 on successive decay_ticks; led_out[0] high for 191/127/63 cycles per 256-cycle window in the respective phases; active falls one cycle after bright[0] reaches 0.
REQ-025 Saturation: DECAY_STEP=100, bright 255 -> 155 -> 55 -> 0 (never wraps to 211); led_out stays 0 thereafter.
REQ-026 Reload collision: led_in[3] asserted in the exact cycle decay_tick fires while bright[3]=127 -> bright[3]=255, not 63.
REQ-027 Flow pattern 8'h80 -> 8'h01 -> 8'h02 every 64 cycles -> led_out shows the current bit fully on and the previous positions at decreasing duty; pwm_cnt wraps 255->0 with no glitch on led_out.
REQ-028 rst_n pulsed low mid-fade (bright[0]=127) -> led_out=8'h00 and active=0 immediately, before the next clk edge; after release all outputs stay 0 while led_in=0.
